// File: rtl/multi_hart_bus_arbiter.sv
// Multi-hart bus arbiter: round-robin sharing of one generic bus among
// NUM_HARTS requester channels, plus the shared mtime counter and per-hart
// mtimecmp / timer_int.

// Per-hart timer lane: one mtimecmp register and its registered interrupt.
module multi_hart_timer_lane (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmp_wen,
  input  logic        cmp_hi,
  input  logic [31:0] cmp_wdata,
  input  logic [63:0] mtime,
  output logic        timer_int
);
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        timer_int_q, timer_int_d;

  // Half-word write into mtimecmp; compare uses the pre-increment mtime.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (cmp_wen) begin
      if (cmp_hi) mtimecmp_d[63:32] = cmp_wdata;
      else        mtimecmp_d[31:0]  = cmp_wdata;
    end
    timer_int_d = (mtime >= mtimecmp_q);
  end

  // Lane state; mtimecmp resets to all ones so no interrupt fires by default.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mtimecmp_q  <= '1;
      timer_int_q <= 1'b0;
    end else begin
      mtimecmp_q  <= mtimecmp_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign timer_int = timer_int_q;
endmodule

module multi_hart_bus_arbiter #(
  parameter int          NUM_HARTS   = 2,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter logic [63:0] MTIME_RESET = 64'h0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_HARTS-1:0]            req_ren,
  input  logic [NUM_HARTS-1:0]            req_wen,
  input  logic [NUM_HARTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_HARTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_HARTS*DATA_W/8-1:0]   req_byte_en,
  output logic [NUM_HARTS-1:0]            req_busy,
  output logic [DATA_W-1:0]               req_rdata,
  output logic [NUM_HARTS-1:0]            req_error,
  output logic                            bus_ren,
  output logic                            bus_wen,
  output logic [ADDR_W-1:0]               bus_addr,
  output logic [DATA_W-1:0]               bus_wdata,
  output logic [DATA_W/8-1:0]             bus_byte_en,
  input  logic                            bus_busy,
  input  logic [DATA_W-1:0]               bus_rdata,
  input  logic                            bus_error,
  input  logic [NUM_HARTS-1:0]            cmp_wen,
  input  logic                            cmp_hi,
  input  logic [31:0]                     cmp_wdata,
  output logic [63:0]                     mtime,
  output logic [NUM_HARTS-1:0]            timer_int
);
  localparam int GW   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, OWN} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [63:0]   mtime_q, mtime_d;

  logic [NUM_HARTS-1:0]             req_any;
  logic [NUM_HARTS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_HARTS-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_HARTS-1:0][BE_W-1:0]   be_a;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW:0]   cand;
  logic [GW-1:0] cand_w;
  logic          own;

  assign req_any = req_ren | req_wen;
  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;
  assign be_a    = req_byte_en;

  // Round-robin pick: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    cand_w     = '0;
    for (int k = 0; k < NUM_HARTS; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_HARTS)) cand = cand - (GW+1)'(NUM_HARTS);
      cand_w = cand[GW-1:0];
      if (!pick_found && req_any[cand_w]) begin
        pick_found = 1'b1;
        pick_idx   = cand_w;
      end
    end
  end

  // Arbiter next state: one IDLE cycle to arbitrate, then OWN until bus_busy drops.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    mtime_d  = mtime_q + 64'd1;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!bus_busy) begin
          if (int'(grant_q) == NUM_HARTS - 1) rr_ptr_d = '0;
          else                                rr_ptr_d = grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter and mtime registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      mtime_q  <= MTIME_RESET;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      mtime_q  <= mtime_d;
    end
  end

  // Reset gates ownership so an in-flight request drops in the reset cycle itself.
  assign own = (state_q == OWN) && !RST;

  // Bus forwarding from the granted channel and per-channel handshake.
  always_comb begin
    bus_ren     = own & req_ren[grant_q];
    bus_wen     = own & req_wen[grant_q];
    bus_addr    = addr_a[grant_q];
    bus_wdata   = wdata_a[grant_q];
    bus_byte_en = be_a[grant_q];
    req_busy    = '1;
    req_error   = '0;
    if (own) begin
      req_busy[grant_q]  = bus_busy;
      req_error[grant_q] = !bus_busy && bus_error;
    end
  end

  assign req_rdata = bus_rdata;
  assign mtime     = mtime_q;

  multi_hart_timer_lane u_lane [NUM_HARTS-1:0] (
    .CLK       (CLK),
    .RST       (RST),
    .cmp_wen   (cmp_wen),
    .cmp_hi    (cmp_hi),
    .cmp_wdata (cmp_wdata),
    .mtime     (mtime_q),
    .timer_int (timer_int)
  );
endmodule

// File: tb/tb_multi_hart_bus_arbiter.sv
// Scoreboard bench: 4-channel arbiter with random requesters, a random-latency
// bus slave and a timer model; a 1-channel instance covers mtime wrap.
module tb_multi_hart_bus_arbiter;
  localparam int N = 4;

  typedef struct {
    int          ch;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    bit          err;
  } tr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // 4-channel instance
  logic [N-1:0]    req_ren = '0, req_wen = '0;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [N*4-1:0]  req_byte_en = '0;
  logic [N-1:0]    req_busy, req_error, timer_int;
  logic [31:0]     req_rdata, bus_addr, bus_wdata;
  logic            bus_ren, bus_wen;
  logic [3:0]      bus_byte_en;
  logic            bus_busy = 1'b1, bus_error = 1'b0;
  logic [31:0]     bus_rdata = '0;
  logic [N-1:0]    cmp_wen = '0;
  logic            cmp_hi = 1'b0;
  logic [31:0]     cmp_wdata = '0;
  logic [63:0]     mtime;

  // 1-channel instance
  logic        req_ren1 = 1'b0, req_wen1 = 1'b0;
  logic [31:0] req_addr1 = 32'h8000_0000, req_wdata1 = '0;
  logic [3:0]  req_byte_en1 = 4'hF;
  logic        req_busy1, req_error1, timer_int1;
  logic [31:0] req_rdata1, bus_addr1, bus_wdata1;
  logic        bus_ren1, bus_wen1;
  logic [3:0]  bus_byte_en1;
  logic        bus_busy1 = 1'b0, bus_error1 = 1'b0;
  logic [31:0] bus_rdata1 = 32'hDEAD_BEEF;
  logic        cmp_wen1 = 1'b0;
  logic [63:0] mtime1;

  multi_hart_bus_arbiter #(.NUM_HARTS(N), .ADDR_W(32), .DATA_W(32), .MTIME_RESET(64'h0)) u0 (
    .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_busy(req_busy), .req_rdata(req_rdata),
    .req_error(req_error), .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en), .bus_busy(bus_busy), .bus_rdata(bus_rdata),
    .bus_error(bus_error), .cmp_wen(cmp_wen), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
    .mtime(mtime), .timer_int(timer_int));

  multi_hart_bus_arbiter #(.NUM_HARTS(1), .ADDR_W(32), .DATA_W(32),
                           .MTIME_RESET(64'hFFFF_FFFF_FFFF_FFFE)) u1 (
    .CLK(CLK), .RST(RST), .req_ren(req_ren1), .req_wen(req_wen1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .req_byte_en(req_byte_en1), .req_busy(req_busy1), .req_rdata(req_rdata1),
    .req_error(req_error1), .bus_ren(bus_ren1), .bus_wen(bus_wen1), .bus_addr(bus_addr1),
    .bus_wdata(bus_wdata1), .bus_byte_en(bus_byte_en1), .bus_busy(bus_busy1), .bus_rdata(bus_rdata1),
    .bus_error(bus_error1), .cmp_wen(cmp_wen1), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
    .mtime(mtime1), .timer_int(timer_int1));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[b*8 +: 8] = w[b*8 +: 8];
    return o;
  endfunction

  // Bus slave: random latency, byte-enabled memory, error on word offsets 3 and 7,
  // junk on busy/rdata/error whenever no transfer is completing.
  bit slv_fast = 0, slv_hold = 0;
  initial begin : slave
    logic [31:0] smem [logic [31:0]];
    bit s_act;
    int s_cnt;
    s_act = 0;
    s_cnt = 0;
    forever begin
      @(posedge CLK); #2;
      if (bus_ren || bus_wen) begin
        if (!s_act) begin
          s_act = 1;
          s_cnt = slv_hold ? 1000 : (slv_fast ? 0 : int'($urandom_range(0, 3)));
        end else if (s_cnt > 0) s_cnt--;
        if (s_cnt == 0) begin
          bus_busy  = 1'b0;
          bus_error = (bus_addr[3:2] == 2'b11);
          bus_rdata = smem.exists(bus_addr) ? smem[bus_addr] : 32'h0;
          if (bus_wen) smem[bus_addr] = merge(bus_rdata, bus_wdata, bus_byte_en);
          s_act = 0;
        end else begin
          bus_busy  = 1'b1;
          bus_rdata = $urandom;
          bus_error = 1'($urandom);
        end
      end else begin
        s_act     = 0;
        bus_busy  = 1'($urandom);
        bus_rdata = $urandom;
        bus_error = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard: opens an expected transaction when a request appears,
  // queues it in predicted grant order, and pops it on the completion cycle.
  initial begin : mon
    logic [31:0] mmem [logic [31:0]];
    tr_t         open_tr [N];
    bit          open_f  [N];
    tr_t         sb_q [$];
    tr_t         e;
    logic [N-1:0] pend, done, nti;
    logic [63:0] mcmp [N];
    logic [63:0] emt, emt1;
    logic [N-1:0] eti;
    bit          eti1, arm1, tv, seen_rst, found;
    int          rr, g;
    seen_rst = 0; tv = 0; rr = 0; emt = 0; emt1 = 0; eti = '0; eti1 = 0; arm1 = 0;
    for (int i = 0; i < N; i++) begin open_f[i] = 0; mcmp[i] = '1; end
    forever begin
      @(negedge CLK);
      if (RST) begin
        seen_rst = 1;
        chk("rst_bus_req", {62'd0, bus_ren, bus_wen}, 64'd0);
        chk("rst_busy", 64'(req_busy), 64'hF);
        chk("rst_error", 64'(req_error), 64'd0);
        chk("rst_bus_req1", 64'(bus_ren1), 64'd0);
        chk("rst_busy1", 64'(req_busy1), 64'd1);
        sb_q.delete();
        for (int i = 0; i < N; i++) begin open_f[i] = 0; mcmp[i] = '1; end
        rr = 0; emt = 64'h0; eti = '0; tv = 1;
        emt1 = 64'hFFFF_FFFF_FFFF_FFFE; eti1 = 0; arm1 = 0;
      end else if (seen_rst) begin
        pend = req_ren | req_wen;
        for (int i = 0; i < N; i++) begin
          if (pend[i] && !open_f[i]) begin
            open_f[i]        = 1;
            open_tr[i].ch    = i;
            open_tr[i].rd    = req_ren[i];
            open_tr[i].addr  = req_addr[i*32 +: 32];
            open_tr[i].wdata = req_wdata[i*32 +: 32];
            open_tr[i].be    = req_byte_en[i*4 +: 4];
            open_tr[i].err   = (((open_tr[i].addr & 32'hFF) / 4) % 4) == 3;
            open_tr[i].rdata = mmem.exists(open_tr[i].addr) ? mmem[open_tr[i].addr] : 32'h0;
            if (!open_tr[i].rd)
              mmem[open_tr[i].addr] = merge(open_tr[i].rdata, open_tr[i].wdata, open_tr[i].be);
          end
        end
        // Bus idle with work pending: the next grant goes to the first pending
        // channel at or after the one following the last served channel.
        if (!bus_ren && !bus_wen && pend != 0) begin
          found = 0; g = 0;
          for (int k = 0; k < N; k++)
            if (!found && pend[(rr + k) % N]) begin found = 1; g = (rr + k) % N; end
          sb_q.push_back(open_tr[g]);
        end
        done = ~req_busy;
        if (done != 0) begin
          if (sb_q.size() == 0) chk("spurious_done", 64'(done), 64'd0);
          else begin
            e = sb_q.pop_front();
            chk("grant_ch", 64'(done), 64'd1 << e.ch);
            chk("bus_addr", 64'(bus_addr), 64'(e.addr));
            chk("bus_op", {62'd0, bus_ren, bus_wen}, e.rd ? 64'd2 : 64'd1);
            if (e.rd) chk("rdata", 64'(req_rdata), 64'(e.rdata));
            else      chk("wdata_be", {28'd0, bus_byte_en, bus_wdata}, {28'd0, e.be, e.wdata});
            chk("req_error", 64'(req_error), e.err ? (64'd1 << e.ch) : 64'd0);
            open_f[e.ch] = 0;
            rr = (e.ch + 1) % N;
          end
        end else chk("error_quiet", 64'(req_error), 64'd0);
        if (tv) begin
          chk("mtime", mtime, emt);
          chk("timer_int", 64'(timer_int), 64'(eti));
          for (int i = 0; i < N; i++) nti[i] = (emt >= mcmp[i]);
          for (int i = 0; i < N; i++)
            if (cmp_wen[i]) begin
              if (cmp_hi) mcmp[i][63:32] = cmp_wdata;
              else        mcmp[i][31:0]  = cmp_wdata;
            end
          emt = emt + 64'd1;
          eti = nti;
          // single-channel instance: continuous reads, bus never busy
          chk("mtime1", mtime1, emt1);
          chk("timer_int1", 64'(timer_int1), 64'(eti1));
          eti1 = (emt1 >= 64'hFFFF_FFFF_FFFF_FFFF);
          emt1 = emt1 + 64'd1;
          chk("busy1", 64'(req_busy1), 64'(!(arm1 && req_ren1)));
          chk("bus_ren1", 64'(bus_ren1), 64'(arm1));
          if (arm1 && req_ren1) chk("rdata1", 64'(req_rdata1), 64'hDEAD_BEEF);
          arm1 = req_ren1 && !arm1;
        end
      end
    end
  end

  // Requester side
  logic [N-1:0] active = '0;

  task automatic issue(input int i);
    active[i] = 1'b1;
    if ($urandom_range(0, 1) == 1) begin req_ren[i] = 1'b1; req_wen[i] = 1'b0; end
    else begin req_ren[i] = 1'b0; req_wen[i] = 1'b1; end
    req_addr[i*32 +: 32]  = 32'h8000_0000 | (32'(i) << 8) | (32'($urandom_range(0, 7)) << 2);
    req_wdata[i*32 +: 32] = $urandom;
    req_byte_en[i*4 +: 4] = 4'($urandom_range(1, 15));
  endtask

  task automatic stim_cycle(input int prob);
    logic [N-1:0] dm;
    @(negedge CLK);
    dm = active & ~req_busy;
    @(posedge CLK); #1;
    for (int i = 0; i < N; i++)
      if (dm[i]) begin active[i] = 1'b0; req_ren[i] = 1'b0; req_wen[i] = 1'b0; end
    cmp_wen = '0;
    if (prob > 0) begin
      for (int i = 0; i < N; i++)
        if (!active[i] && $urandom_range(0, prob - 1) == 0) issue(i);
      if ($urandom_range(0, 5) == 0) begin
        cmp_wen   = 4'($urandom_range(1, 15));
        cmp_hi    = ($urandom_range(0, 3) == 0);
        cmp_wdata = cmp_hi ? 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 4000));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (active != 0 && n < 300) begin stim_cycle(0); n++; end
    if (active != 0) begin
      $display("FAIL drain_timeout: got active=%0h expected 0", active);
      $fatal(1, "requests never completed");
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    req_ren1 = 1'b1;
    repeat (1500) stim_cycle(3);
    slv_fast = 1;
    repeat (300) stim_cycle(1);
    slv_fast = 0;
    drain();
    // Reset while a transfer is held busy on channel 2.
    slv_hold = 1;
    issue(2);
    repeat (4) stim_cycle(0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    active = '0; req_ren = '0; req_wen = '0;
    slv_hold = 0;
    repeat (1000) stim_cycle(3);
    drain();
    repeat (5) stim_cycle(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_hart_bus_arbiter.md
Name: multi_hart_bus_arbiter

Overview:
Parametrised successor to the single-core top-level wrapper. It lets NUM_HARTS cores share one external generic bus port. Each core presents a generic-bus requester channel, and the block arbitrates among them round-robin. It also holds the shared 64-bit mtime counter and a per-hart mtimecmp register, and drives each hart's timer_int. It sits between the core instances and the single off-chip generic bus in the multi-hart top.

Parameters:
NUM_HARTS, 2, number of requester channels / harts (1..16)
ADDR_W, 32, bus address width
DATA_W, 32, bus data width; byte_en width = DATA_W/8
MTIME_RESET, 64'h0, mtime value after reset

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
req_ren  in  NUM_HARTS  per-channel read request
req_wen  in  NUM_HARTS  per-channel write request
req_addr  in  NUM_HARTS*ADDR_W  per-channel address; channel i occupies slice [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_HARTS*DATA_W  per-channel write data
req_byte_en  in  NUM_HARTS*DATA_W/8  per-channel byte enables
req_busy  out  NUM_HARTS  per-channel busy; low only in a channel's completion cycle
req_rdata  out  DATA_W  read data, broadcast to all channels
req_error  out  NUM_HARTS  per-channel error, valid in the completion cycle
bus_ren, bus_wen  out  1  external bus request
bus_addr  out  ADDR_W  external bus address
bus_wdata  out  DATA_W  external bus write data
bus_byte_en  out  DATA_W/8  external bus byte enables
bus_busy  in  1  external bus busy
bus_rdata  in  DATA_W  external bus read data
bus_error  in  1  external bus error
cmp_wen  in  NUM_HARTS  per-hart mtimecmp write strobe
cmp_hi  in  1  1 = write bits [63:32], 0 = write bits [31:0]
cmp_wdata  in  32  mtimecmp write data
mtime  out  64  shared machine timer
timer_int  out  NUM_HARTS  per-hart timer interrupt, registered

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE, grant=0, rr_ptr=0.
  - mtime=MTIME_RESET; every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; timer_int=0.
  - Outputs during and after reset: bus_ren=bus_wen=0, req_busy=all 1s, req_error=0.
- Arbiter FSM has two states, IDLE and OWN.
  - IDLE:
    - bus_ren=bus_wen=0; req_busy all 1s.
    - If any channel has ren|wen, grant <= first requesting index searching upward from rr_ptr with wrap-around; next state OWN.
    - Arbitration costs exactly 1 cycle.
  - OWN:
    - bus_* outputs are driven combinationally from channel grant.
    - req_busy[grant]=bus_busy; every other channel's req_busy=1.
    - When bus_busy=0, that cycle is the completion cycle:
      - req_rdata=bus_rdata; req_error[grant]=bus_error.
      - rr_ptr <= (grant+1) mod NUM_HARTS; next state IDLE.
    - While bus_busy=1, remain in OWN.
  - Minimum per-transaction latency is 2 cycles. Back-to-back requests from one channel therefore see at least one busy cycle between completions.
- Requester rule: a channel holds ren/wen/addr/wdata/byte_en stable until it sees busy low. The arbiter does not abort a granted transaction.
  - ren and wen both asserted on a channel is a protocol error. The bus sees both as forwarded.
  - req_error is 0 in every non-completion cycle.
- Fairness: a continuously requesting channel is granted within NUM_HARTS transactions.
- NUM_HARTS=1: rr_ptr is constant 0. Behaviour is otherwise identical (IDLE cycle still present).
- Timer:
  - mtime increments by 1 every cycle not in reset, wrapping from 2^64-1 to 0.
  - cmp_wen[i] writes cmp_wdata into the half of mtimecmp[i] selected by cmp_hi. Multiple bits may be set in the same cycle; all selected harts are written.
  - timer_int[i] <= (mtime >= mtimecmp[i]), unsigned 64-bit compare using the pre-increment mtime. This gives 1-cycle latency.
  - A write to mtimecmp affects timer_int starting the cycle after the write.
- Reset mid-transaction: state returns to IDLE immediately and the bus request is dropped the same cycle. No completion is signalled.

Test Plan:
1. Single read: ch0 ren, addr 0x8000_0000; bus_busy low on 2nd OWN cycle with rdata 0xDEADBEEF -> bus_ren high 2 cycles, req_busy[0] low exactly once, req_rdata=0xDEADBEEF, req_busy[1] stays 1.
2. Contention, NUM_HARTS=4: all channels request continuously, bus_busy always 0 -> grant order 0,1,2,3,0; each completion 2 cycles apart.
3. Error path: ch1 wen, bus_error=1 in completion cycle -> req_error=4'b0010 for that cycle only, then 0.
4. Timer: mtimecmp[1] written lo=0x10, hi=0 at mtime=0x8 -> timer_int[1] rises on the cycle after mtime=0x10; timer_int[0] stays 0.
5. Reset mid-transaction: RST asserted while OWN with bus_busy=1 -> next cycle bus_ren=0, state IDLE, mtime=0, no req_busy low pulse.
6. mtime wrap: MTIME_RESET=64'hFFFF_FFFF_FFFF_FFFE -> mtime reads ...FFFF, then 0. A hart with mtimecmp=...FFFF asserts timer_int, then deasserts after the wrap.
